// File: rtl/pipeline_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, fetch FSM
// states and the default reset PC.
package pipeline_if_stage_pkg;

  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } if_state_e;

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'd3;
  endfunction

endpackage

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage: one outstanding imem request, a one-entry hold
// buffer for words that arrive while decode stalls, and redirect/flush handling.
//
// state  | meaning
// S_REQ  | imem_req=1 at pc_q, waiting for imem_ready
// S_WAIT | request accepted, waiting for imem_rvalid
// S_HOLD | fetched word parked in the buffer while decode stalls
// S_DROP | redirected while a request is in flight; discard its response
module pipeline_if_stage
  import pipeline_if_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_IF,
  output logic [63:0] pc_IF,
  output logic        valid_IF
);

  if_state_e   state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] buf_insn_q, buf_insn_d;
  logic [63:0] buf_pc_q, buf_pc_d;
  logic [31:0] insn_q, insn_d;
  logic [63:0] pc_if_q, pc_if_d;
  logic        valid_q, valid_d;

  logic        new_word;
  logic [31:0] word;
  logic [63:0] word_pc;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_insn_d = buf_insn_q;
    buf_pc_d   = buf_pc_q;
    new_word   = 1'b0;
    word       = NOP_INSN;
    word_pc    = '0;

    case (state_q)
      S_REQ: begin
        if (imem_ready) state_d = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) begin
            state_d = S_REQ;
          end else begin
            pc_d = pc_q + 64'd4;
            if (stall) begin
              state_d    = S_HOLD;
              buf_insn_d = imem_rdata;
              buf_pc_d   = pc_q;
            end else begin
              state_d  = S_REQ;
              new_word = 1'b1;
              word     = imem_rdata;
              word_pc  = pc_q;
            end
          end
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (!stall) begin
          state_d  = S_REQ;
          new_word = 1'b1;
          word     = buf_insn_q;
          word_pc  = buf_pc_q;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_valid) pc_d = align_pc(redirect_pc);
  end

  // Output register: redirect/flush squash, stall freezes, otherwise word or bubble.
  always_comb begin
    insn_d  = insn_q;
    pc_if_d = pc_if_q;
    valid_d = valid_q;
    if (redirect_valid || flush) begin
      insn_d  = NOP_INSN;
      pc_if_d = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (new_word) begin
        insn_d  = word;
        pc_if_d = word_pc;
        valid_d = 1'b1;
      end else begin
        insn_d  = NOP_INSN;
        pc_if_d = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      buf_insn_q <= NOP_INSN;
      buf_pc_q   <= '0;
      insn_q     <= NOP_INSN;
      pc_if_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_insn_q <= buf_insn_d;
      buf_pc_q   <= buf_pc_d;
      insn_q     <= insn_d;
      pc_if_q    <= pc_if_d;
      valid_q    <= valid_d;
    end
  end

  // Gating with reset keeps the request low while reset is held.
  assign imem_req       = reset && (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign instruction_IF = insn_q;
  assign pc_IF          = pc_if_q;
  assign valid_IF       = valid_q;

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Scoreboard bench for pipeline_if_stage: a transaction-level fetch model pushes
// expected (pc, word, cycle) entries; a negedge monitor pops and compares them.
module tb_pipeline_if_stage;
  import pipeline_if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_IF;
  logic [63:0] pc_IF;
  logic        valid_IF;

  always #5 clk = ~clk;

  pipeline_if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction_IF(instruction_IF), .pc_IF(pc_IF), .valid_IF(valid_IF)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model state: expected fetch PC, one in-flight token, one held word.
  logic [63:0] exp_pc;
  bit          mem_busy;
  int          mem_cnt;
  logic [63:0] mem_addr;
  logic [63:0] tok_pc;
  bit          tok_stale;
  bit          held_v;
  logic [63:0] held_pc;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h8) return 32'h0050_0093;
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [63:0] pc);
    exp_t e;
    e.pc   = pc;
    e.insn = mem_word(pc);
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_pc    = DEFAULT_RESET_PC;
    mem_busy  = 0;
    mem_cnt   = 0;
    mem_addr  = '0;
    tok_pc    = '0;
    tok_stale = 0;
    held_v    = 0;
    held_pc   = '0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, predict its effect, then advance past the edge.
  task automatic step(input bit st, input bit fl, input bit rd, input logic [63:0] rpc,
                      input bit rdy, input int lat);
    bit rv, acc;
    if (mem_busy) mem_cnt--;
    rv = mem_busy && (mem_cnt == 0);
    stall          = st;
    flush          = fl;
    redirect_valid = rd;
    redirect_pc    = rpc;
    imem_ready     = rdy;
    imem_rvalid    = rv;
    imem_rdata     = rv ? mem_word(mem_addr) : $urandom;
    acc = imem_req && rdy;
    if (imem_req) chk("one_outstanding", 64'(mem_busy), 64'd0);
    if (acc) begin
      chk("fetch_addr", imem_addr, exp_pc);
      mem_busy  = 1;
      mem_cnt   = lat;
      mem_addr  = imem_addr;
      tok_pc    = exp_pc;
      tok_stale = 0;
    end
    if (rd) begin
      exp_pc = rpc & ~64'd3;
      held_v = 0;
      if (mem_busy) tok_stale = 1;
    end else if (rv && !tok_stale) begin
      exp_pc = exp_pc + 64'd4;
      if (st) begin
        held_v  = 1;
        held_pc = tok_pc;
      end else if (!fl) begin
        push_exp(tok_pc);
      end
    end else if (held_v && !st) begin
      if (!fl) push_exp(held_pc);
      held_v = 0;
    end
    @(posedge clk);
    if (rv) mem_busy = 0;
    #1;
  endtask

  // Monitor: pops an entry whenever a new word is presented on the outputs.
  logic [31:0] p_insn;
  logic [63:0] p_pc;
  logic        p_valid;
  bit          p_hold = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      p_hold = 0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_checks++; n_err++;
        $display("FAIL missing_word: pc %0h never presented (due cycle %0d)", e.pc, e.cyc);
      end
      if (!p_hold && valid_IF) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          chk("word_pc", pc_IF, e.pc);
          chk("word_insn", 64'(instruction_IF), 64'(e.insn));
        end else begin
          n_checks++; n_err++;
          $display("FAIL unexpected_valid: pc_IF=%0h insn=%0h required no valid word", pc_IF, instruction_IF);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_checks++; n_err++;
        $display("FAIL missing_word: valid_IF=%0b pc_IF=%0h required pc %0h", valid_IF, pc_IF, e.pc);
      end
      if (p_hold) begin
        chk("hold_insn", 64'(instruction_IF), 64'(p_insn));
        chk("hold_pc", pc_IF, p_pc);
        chk("hold_valid", 64'(valid_IF), 64'(p_valid));
      end
      if (!valid_IF) begin
        chk("bubble_insn", 64'(instruction_IF), 64'(NOP_INSN));
        chk("bubble_pc", pc_IF, 64'd0);
      end
      p_insn  = instruction_IF;
      p_pc    = pc_IF;
      p_valid = valid_IF;
      p_hold  = stall && !flush && !redirect_valid;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 64'(imem_req), 64'd0);
    chk({tag, "_valid"}, 64'(valid_IF), 64'd0);
    chk({tag, "_insn"}, 64'(instruction_IF), 64'(NOP_INSN));
    chk({tag, "_pc"}, pc_IF, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rpc;
    reset = 1'b0;
    stall = 0; flush = 0; redirect_valid = 0; redirect_pc = '0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    #1 reset = 1'b1;
    #1;
    chk("post_reset_req", 64'(imem_req), 64'd1);
    chk("post_reset_addr", imem_addr, DEFAULT_RESET_PC);

    // Straight-line fetch with a 1-cycle memory: valid words alternate with bubbles.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 64'h0, 1, 1);
      chk("straight_valid", 64'(valid_IF), 64'(i % 2));
    end

    // Word at pc 0x8 returns under a 3-cycle stall.
    step(0, 0, 0, 64'h0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 64'h0, 1, 1);
      chk("stall_frozen", 64'(valid_IF), 64'd0);
    end
    step(0, 0, 0, 64'h0, 1, 1);
    chk("stall_release_insn", 64'(instruction_IF), 64'h0050_0093);
    chk("stall_release_pc", pc_IF, 64'h8);
    chk("stall_release_valid", 64'(valid_IF), 64'd1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 64'h0, 1, 1);

    // Redirect while waiting; stale response arrives two cycles later.
    step(0, 0, 0, 64'h0, 1, 3);
    step(0, 0, 1, 64'h100, 1, 1);
    chk("redir_wait_valid", 64'(valid_IF), 64'd0);
    step(0, 0, 0, 64'h0, 0, 1);
    chk("redir_wait_valid", 64'(valid_IF), 64'd0);
    step(0, 0, 0, 64'h0, 0, 1);
    chk("redir_wait_valid", 64'(valid_IF), 64'd0);
    chk("redir_wait_req", 64'(imem_req), 64'd1);
    chk("redir_wait_addr", imem_addr, 64'h100);

    // Unaligned redirect while a word sits in the hold buffer.
    step(0, 0, 0, 64'h0, 1, 1);
    step(1, 0, 0, 64'h0, 0, 1);
    step(1, 0, 1, 64'h103, 0, 1);
    chk("redir_hold_req", 64'(imem_req), 64'd1);
    chk("redir_hold_addr", imem_addr, 64'h100);
    chk("redir_hold_valid", 64'(valid_IF), 64'd0);
    step(0, 0, 0, 64'h0, 0, 1);
    chk("redir_hold_dropped", 64'(valid_IF), 64'd0);

    // Flush together with stall squashes a presented word; fetch PC untouched.
    step(0, 0, 0, 64'h0, 1, 1);
    step(0, 0, 0, 64'h0, 0, 1);
    chk("pre_flush_valid", 64'(valid_IF), 64'd1);
    step(1, 1, 0, 64'h0, 0, 1);
    chk("flush_insn", 64'(instruction_IF), 64'(NOP_INSN));
    chk("flush_valid", 64'(valid_IF), 64'd0);
    chk("flush_pc_reg", imem_addr, 64'h104);

    // Asynchronous reset between edges while a request is outstanding.
    step(0, 0, 0, 64'h0, 1, 1);
    step(0, 0, 0, 64'h0, 0, 1);
    step(1, 0, 0, 64'h0, 1, 3);
    chk("pre_reset_valid", 64'(valid_IF), 64'd1);
    #2 reset = 1'b0;
    stall = 0; flush = 0; redirect_valid = 0; imem_ready = 0; imem_rvalid = 0;
    model_reset();
    #1;
    chk_reset_outputs("async_reset");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rerelease_req", 64'(imem_req), 64'd1);
    chk("rerelease_addr", imem_addr, DEFAULT_RESET_PC);

    // Randomized traffic, including redirects near the top of the address space.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = {$urandom, $urandom};
        1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        default: rpc = 64'($urandom_range(0, 4095));
      endcase
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0, rpc,
           $urandom_range(0, 2) != 0, $urandom_range(1, 4));
    end

    for (int i = 0; i < 12; i++) step(0, 0, 0, 64'h0, 1, 1);
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_if_stage.md
PIPELINE_IF_STAGE -- requirements
Module: pipeline_if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port stall, input, 1, meaning the decode stage holds and does not consume instruction_IF this cycle.
REQ-005 The block SHALL have port flush, input, 1, meaning the current instruction_IF is squashed.
REQ-006 The block SHALL have port redirect_valid, input, 1, meaning a taken branch or jump from execute.
REQ-007 The block SHALL have port redirect_pc, input, 64, the redirect target.
REQ-008 The block SHALL have port imem_req, output, 1, the fetch request valid.
REQ-009 The block SHALL have port imem_addr, output, 64, the fetch address.
REQ-010 The block SHALL have port imem_ready, input, 1, meaning the request is accepted this cycle.
REQ-011 The block SHALL have port imem_rvalid, input, 1, the response valid.
REQ-012 The block SHALL have port imem_rdata, input, 32, the response instruction word.
REQ-013 The block SHALL have port instruction_IF, output, 32, the instruction presented to decode.
REQ-014 The block SHALL have port pc_IF, output, 64, the PC of instruction_IF.
REQ-015 The block SHALL have port valid_IF, output, 1, meaning instruction_IF is a real fetched instruction.

Function
REQ-016 The block SHALL keep at most one imem request outstanding; memory latency is variable, with at least 1 cycle from acceptance to rvalid.
REQ-017 The block SHALL implement four states: S_REQ (imem_req=1, imem_addr=pc_reg), S_WAIT (awaiting rvalid), S_HOLD (fetched word buffered while stall=1), and S_DROP (awaiting a stale response to discard).
REQ-018 The block SHALL make the following transitions: S_REQ->S_WAIT on imem_ready; S_WAIT->S_REQ on rvalid with stall=0; S_WAIT->S_HOLD on rvalid with stall=1; S_HOLD->S_REQ when stall=0; S_DROP->S_REQ on rvalid.
REQ-019 The block SHALL, on rvalid with stall=0 in S_WAIT, register instruction_IF<=imem_rdata, pc_IF<=pc_reg and valid_IF<=1, and advance pc_reg by 4 (modulo 2^64).
REQ-020 The block SHALL, on rvalid with stall=1 in S_WAIT, store the word and its PC in a one-entry buffer, advance pc_reg by 4, and leave the outputs unchanged.
REQ-021 The block SHALL, in S_HOLD when stall=0, load the outputs from the buffer with valid_IF=1.
REQ-022 The block SHALL hold all outputs unchanged in every cycle with stall=1.
REQ-023 The block SHALL, in every cycle with stall=0 and no new word from REQ-019 or REQ-021, load the bubble: instruction_IF=32'h00000013, pc_IF=0, valid_IF=0.
REQ-024 The block SHALL, when flush=1, load the bubble regardless of stall; flush SHALL NOT alter pc_reg or state.
REQ-025 The block SHALL, when redirect_valid=1, load pc_reg<={redirect_pc[63:2],2'b00} and the bubble, overriding stall, flush and the PC increment.
REQ-026 The block SHALL determine the next state under redirect_valid=1 as follows:
- S_REQ with imem_ready: ->S_DROP.
- S_REQ without imem_ready: stay in S_REQ.
- S_WAIT without rvalid: ->S_DROP.
- S_WAIT with rvalid: discard the word, ->S_REQ.
- S_HOLD: discard the buffer, ->S_REQ.
- S_DROP without rvalid: stay in S_DROP with the new pc_reg.
- S_DROP with rvalid: ->S_REQ.
REQ-027 The block SHALL never present a discarded word on instruction_IF.

Reset
REQ-028 The block SHALL, while reset=0, force pc_reg=RESET_PC, state=S_REQ, buffer empty, instruction_IF=32'h00000013, pc_IF=0, valid_IF=0 and imem_req=0.
REQ-029 The block SHALL present imem_req=1 with imem_addr=RESET_PC in the first cycle after reset deasserts.
REQ-030 The block SHALL treat a reset asserted mid-request as abandoning that request; the environment resets imem together with this block.

Structure
REQ-031 The NOP encoding 32'h00000013, the state encodings and the default RESET_PC SHALL reside in the shared pipeline package.
REQ-032 The block SHALL be a single module with no sub-module; pc_reg+4 is inline.

Verification
REQ-033 The bench SHALL cover straight-line fetch: 1-cycle memory, stall=0 -> PCs 0,4,8,... appear on consecutive request/response pairs with valid_IF=1 and bubbles between.
REQ-034 The bench SHALL cover stall at the response: rvalid with word 0x00500093 at pc=0x8 while stall=1 for 3 cycles -> outputs frozen, then the word appears with pc_IF=0x8 on the first cycle after stall=0.
REQ-035 The bench SHALL cover redirect in S_WAIT: redirect_pc=0x100, rvalid arrives 2 cycles later -> that word is dropped, next imem_addr=0x100, and no stale valid_IF.
REQ-036 The bench SHALL cover redirect with an unaligned target: redirect_pc=0x103 in S_HOLD -> buffer discarded, imem_addr=0x100.
REQ-037 The bench SHALL cover flush together with stall: flush=1 and stall=1 -> instruction_IF=0x13, valid_IF=0 on the next cycle, with pc_reg unchanged.
REQ-038 The bench SHALL cover async reset: reset=0 asserted mid-S_WAIT between clock edges -> outputs immediately return to reset values; after release, imem_addr=RESET_PC.
